// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: fetch, data and memory-port signals of the arbiter.
// slave = arbiter side, master = requester/memory side.
interface mem_port_arbiter_if #(
  parameter int REG_WIDTH = 16
);
  logic                 i_1_if_req;
  logic [REG_WIDTH-1:0] i_R_if_addr;
  logic                 o_1_if_gnt;
  logic [REG_WIDTH-1:0] or_R_if_rdata;
  logic                 or_1_if_valid;
  logic                 i_1_dm_req;
  logic                 i_1_dm_wr_en;
  logic [REG_WIDTH-1:0] i_R_dm_addr;
  logic [REG_WIDTH-1:0] i_R_dm_wdata;
  logic                 o_1_dm_gnt;
  logic [REG_WIDTH-1:0] or_R_dm_rdata;
  logic                 or_1_dm_valid;
  logic                 or_1_mem_en;
  logic                 or_1_mem_wr_en;
  logic [REG_WIDTH-1:0] or_R_mem_addr;
  logic [REG_WIDTH-1:0] or_R_mem_wdata;
  logic [REG_WIDTH-1:0] i_R_mem_rdata;
  logic                 o_1_busy;

  modport slave (
    input  i_1_if_req, i_R_if_addr,
    output o_1_if_gnt, or_R_if_rdata, or_1_if_valid,
    input  i_1_dm_req, i_1_dm_wr_en, i_R_dm_addr, i_R_dm_wdata,
    output o_1_dm_gnt, or_R_dm_rdata, or_1_dm_valid,
    output or_1_mem_en, or_1_mem_wr_en, or_R_mem_addr, or_R_mem_wdata,
    input  i_R_mem_rdata,
    output o_1_busy
  );

  modport master (
    output i_1_if_req, i_R_if_addr,
    input  o_1_if_gnt, or_R_if_rdata, or_1_if_valid,
    output i_1_dm_req, i_1_dm_wr_en, i_R_dm_addr, i_R_dm_wdata,
    input  o_1_dm_gnt, or_R_dm_rdata, or_1_dm_valid,
    input  or_1_mem_en, or_1_mem_wr_en, or_R_mem_addr, or_R_mem_wdata,
    output i_R_mem_rdata,
    input  o_1_busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: one memory port shared by fetch and data access, DM first.
// Define MEM_PORT_ARB_STARVE_GUARD_EN to force an IF grant after STARVE_MAX DM wins.
module mem_port_arbiter #(
  parameter int REG_WIDTH  = 16,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input logic               clk,
  input logic               rst_n,
  mem_port_arbiter_if.slave bus
);
  localparam int CW = $clog2(MEM_LAT + 1) + 1;

  if (MEM_LAT < 1 || STARVE_MAX < 1) begin : g_param_chk
    $error("mem_port_arbiter: MEM_LAT and STARVE_MAX must be >= 1");
  end

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } state_e;

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 own_dm_q, own_dm_d;
  logic                 acc_wr_q, acc_wr_d;
  logic                 en_q, en_d;
  logic                 wr_q, wr_d;
  logic [REG_WIDTH-1:0] addr_q, addr_d;
  logic [REG_WIDTH-1:0] wdata_q, wdata_d;
  logic [REG_WIDTH-1:0] if_rdata_q, if_rdata_d;
  logic [REG_WIDTH-1:0] dm_rdata_q, dm_rdata_d;
  logic                 if_valid_q, if_valid_d;
  logic                 dm_valid_q, dm_valid_d;

  logic idle_ok;
  logic force_if;
  logic dm_gnt;
  logic if_gnt;

  // Grants are gated by reset so nothing is accepted while held in reset.
  assign idle_ok = (state_q == IDLE) && rst_n;
  assign dm_gnt  = idle_ok && bus.i_1_dm_req
                && !(force_if && bus.i_1_if_req);
  assign if_gnt  = idle_ok && bus.i_1_if_req
                && (!bus.i_1_dm_req || force_if);

`ifdef MEM_PORT_ARB_STARVE_GUARD_EN
  localparam int SW = $clog2(STARVE_MAX + 1);

  logic [SW-1:0] starve_q, starve_d;

  assign force_if = (starve_q >= SW'(STARVE_MAX));

  always_comb begin
    starve_d = starve_q;
    if (if_gnt) begin
      starve_d = '0;
    end else if (dm_gnt) begin
      starve_d = bus.i_1_if_req ? starve_q + 1'b1 : '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end
`else
  assign force_if = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    own_dm_d   = own_dm_q;
    acc_wr_d   = acc_wr_q;
    en_d       = 1'b0;
    wr_d       = 1'b0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    if_rdata_d = if_rdata_q;
    dm_rdata_d = dm_rdata_q;
    if_valid_d = 1'b0;
    dm_valid_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (dm_gnt || if_gnt) begin
          state_d  = ISSUE;
          own_dm_d = dm_gnt;
          acc_wr_d = dm_gnt && bus.i_1_dm_wr_en;
          en_d     = 1'b1;
          wr_d     = dm_gnt && bus.i_1_dm_wr_en;
          addr_d   = dm_gnt ? bus.i_R_dm_addr : bus.i_R_if_addr;
          if (dm_gnt) begin
            wdata_d = bus.i_R_dm_wdata;
          end
        end
      end
      ISSUE: begin
        state_d = WAIT;
        cnt_d   = CW'(1);
      end
      WAIT: begin
        if (cnt_q == CW'(MEM_LAT)) begin
          state_d = IDLE;
          cnt_d   = '0;
          if (own_dm_q) begin
            dm_valid_d = 1'b1;
            if (!acc_wr_q) begin
              dm_rdata_d = bus.i_R_mem_rdata;
            end
          end else begin
            if_valid_d = 1'b1;
            if_rdata_d = bus.i_R_mem_rdata;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      own_dm_q   <= 1'b0;
      acc_wr_q   <= 1'b0;
      en_q       <= 1'b0;
      wr_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
      if_valid_q <= 1'b0;
      dm_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      own_dm_q   <= own_dm_d;
      acc_wr_q   <= acc_wr_d;
      en_q       <= en_d;
      wr_q       <= wr_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      if_rdata_q <= if_rdata_d;
      dm_rdata_q <= dm_rdata_d;
      if_valid_q <= if_valid_d;
      dm_valid_q <= dm_valid_d;
    end
  end

  assign bus.o_1_if_gnt     = if_gnt;
  assign bus.o_1_dm_gnt     = dm_gnt;
  assign bus.or_R_if_rdata  = if_rdata_q;
  assign bus.or_1_if_valid  = if_valid_q;
  assign bus.or_R_dm_rdata  = dm_rdata_q;
  assign bus.or_1_dm_valid  = dm_valid_q;
  assign bus.or_1_mem_en    = en_q;
  assign bus.or_1_mem_wr_en = wr_q;
  assign bus.or_R_mem_addr  = addr_q;
  assign bus.or_R_mem_wdata = wdata_q;
  assign bus.o_1_busy       = (state_q != IDLE);
endmodule
